issue_queue: RTL and testbench

Dual-dispatch, dual-issue, age-ordered collapsing issue queue sitting directly downstream of decode/rename and the busy table. It accepts up to two instructions per cycle with per-source ready bits, performs tag wakeup, selects the two oldest ready entries per cycle into registered issue slots, and drives the select-stage destination addresses back to the busy table.

---
 rtl/issue_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_issue_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue: dual-dispatch, dual-issue, age-ordered collapsing issue queue.
//
// Entries live at indices 0..count-1, with index 0 the oldest. Each cycle the
// two oldest ready entries are selected into registered issue slots. The
// survivors collapse toward index 0, and up to two new instructions are
// appended behind them.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   flush              synchronous clear of all entries and issue slots
//   disp_inst{1,2}_*   dispatch slots (valid, payload, srcs, src ready bits,
//                      dest, rf_we)
//   disp_ready         at least two free entries, computed from the
//                      registered count
//   wb_inst{1,2}_dest  writeback wakeup tags (0 = none)
//   iss_stall          downstream stall; freezes selection and issue slots
//   iss_inst{1,2}_*    registered issue slots (valid, payload, dest)
//   sel_inst{1,2}_dest destinations selected this cycle, sent to the busy table
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 64,
    parameter int REG_NUM   = 32,
    localparam int AW       = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 disp_inst1_valid,
    input  logic [PAYLOAD_W-1:0] disp_inst1_payload,
    input  logic [AW-1:0]        disp_inst1_src1,
    input  logic [AW-1:0]        disp_inst1_src2,
    input  logic                 disp_inst1_src1_ready,
    input  logic                 disp_inst1_src2_ready,
    input  logic [AW-1:0]        disp_inst1_dest,
    input  logic                 disp_inst1_rf_we,
    input  logic                 disp_inst2_valid,
    input  logic [PAYLOAD_W-1:0] disp_inst2_payload,
    input  logic [AW-1:0]        disp_inst2_src1,
    input  logic [AW-1:0]        disp_inst2_src2,
    input  logic                 disp_inst2_src1_ready,
    input  logic                 disp_inst2_src2_ready,
    input  logic [AW-1:0]        disp_inst2_dest,
    input  logic                 disp_inst2_rf_we,
    output logic                 disp_ready,
    input  logic [AW-1:0]        wb_inst1_dest,
    input  logic [AW-1:0]        wb_inst2_dest,
    input  logic                 iss_stall,
    output logic                 iss_inst1_valid,
    output logic [PAYLOAD_W-1:0] iss_inst1_payload,
    output logic [AW-1:0]        iss_inst1_dest,
    output logic                 iss_inst2_valid,
    output logic [PAYLOAD_W-1:0] iss_inst2_payload,
    output logic [AW-1:0]        iss_inst2_dest,
    output logic [AW-1:0]        sel_inst1_dest,
    output logic [AW-1:0]        sel_inst2_dest
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [AW-1:0]        src1;
        logic [AW-1:0]        src2;
        logic                 src1_rdy;
        logic                 src2_rdy;
        logic [AW-1:0]        dest;
        logic                 rf_we;
    } entry_t;

    entry_t               entry_q [DEPTH];
    entry_t               entry_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic                 iss1_valid_q, iss1_valid_d, iss2_valid_q, iss2_valid_d;
    logic [PAYLOAD_W-1:0] iss1_payload_q, iss1_payload_d, iss2_payload_q, iss2_payload_d;
    logic [AW-1:0]        iss1_dest_q, iss1_dest_d, iss2_dest_q, iss2_dest_d;

    logic [DEPTH-1:0]     ready;
    logic                 sel1_found, sel2_found;
    logic [IW-1:0]        sel1_idx, sel2_idx;
    entry_t               new1, new2, cand;
    logic                 keep;
    logic [CW-1:0]        pos;

    // A tag of 0 never matches because a zero source is rejected first.
    function automatic logic tag_hit(input logic [AW-1:0] src, input logic [AW-1:0] t0,
                                     input logic [AW-1:0] t1, input logic [AW-1:0] t2,
                                     input logic [AW-1:0] t3);
        return (src != '0) && ((src == t0) || (src == t1) || (src == t2) || (src == t3));
    endfunction

    assign disp_ready = (count_q <= CW'(DEPTH - 2));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
            assign ready[gi] = entry_q[gi].valid && entry_q[gi].src1_rdy && entry_q[gi].src2_rdy;
        end
    endgenerate

    // Oldest and next-oldest ready entries; nothing is selected while stalled.
    always_comb begin
        sel1_found     = 1'b0;
        sel2_found     = 1'b0;
        sel1_idx       = '0;
        sel2_idx       = '0;
        if (!iss_stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ready[i]) begin
                    if (!sel1_found) begin
                        sel1_found = 1'b1;
                        sel1_idx   = IW'(i);
                    end else if (!sel2_found) begin
                        sel2_found = 1'b1;
                        sel2_idx   = IW'(i);
                    end
                end
            end
        end
        sel_inst1_dest = (sel1_found && entry_q[sel1_idx].rf_we) ? entry_q[sel1_idx].dest : '0;
        sel_inst2_dest = (sel2_found && entry_q[sel2_idx].rf_we) ? entry_q[sel2_idx].dest : '0;
    end

    // Incoming entries also see this cycle's wakeup tags, so a busy-table
    // clear landing at the same edge is not lost.
    always_comb begin
        new1.valid    = 1'b1;
        new1.payload  = disp_inst1_payload;
        new1.src1     = disp_inst1_src1;
        new1.src2     = disp_inst1_src2;
        new1.src1_rdy = disp_inst1_src1_ready || (disp_inst1_src1 == '0) ||
                        tag_hit(disp_inst1_src1, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
        new1.src2_rdy = disp_inst1_src2_ready || (disp_inst1_src2 == '0) ||
                        tag_hit(disp_inst1_src2, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
        new1.dest     = disp_inst1_dest;
        new1.rf_we    = disp_inst1_rf_we;
        new2.valid    = 1'b1;
        new2.payload  = disp_inst2_payload;
        new2.src1     = disp_inst2_src1;
        new2.src2     = disp_inst2_src2;
        new2.src1_rdy = disp_inst2_src1_ready || (disp_inst2_src1 == '0) ||
                        tag_hit(disp_inst2_src1, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
        new2.src2_rdy = disp_inst2_src2_ready || (disp_inst2_src2 == '0) ||
                        tag_hit(disp_inst2_src2, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
        new2.dest     = disp_inst2_dest;
        new2.rf_we    = disp_inst2_rf_we;
    end

    // Collapse the survivors (with wakeup applied), then append dispatches.
    always_comb begin
        pos  = '0;
        keep = 1'b0;
        cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            keep = entry_q[i].valid &&
                   !(sel1_found && (sel1_idx == IW'(i))) &&
                   !(sel2_found && (sel2_idx == IW'(i)));
            if (keep) begin
                cand          = entry_q[i];
                cand.src1_rdy = cand.src1_rdy ||
                                tag_hit(cand.src1, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                cand.src2_rdy = cand.src2_rdy ||
                                tag_hit(cand.src2, sel_inst1_dest, sel_inst2_dest, wb_inst1_dest, wb_inst2_dest);
                entry_d[pos[IW-1:0]] = cand;
                pos = pos + CW'(1);
            end
        end
        if (disp_ready) begin
            if (disp_inst1_valid && (pos < CW'(DEPTH))) begin
                entry_d[pos[IW-1:0]] = new1;
                pos = pos + CW'(1);
            end
            if (disp_inst2_valid && (pos < CW'(DEPTH))) begin
                entry_d[pos[IW-1:0]] = new2;
                pos = pos + CW'(1);
            end
        end
        count_d = pos;
    end

    // Issue slots reload every unstalled cycle; an empty select clears them.
    always_comb begin
        iss1_valid_d   = iss1_valid_q;
        iss1_payload_d = iss1_payload_q;
        iss1_dest_d    = iss1_dest_q;
        iss2_valid_d   = iss2_valid_q;
        iss2_payload_d = iss2_payload_q;
        iss2_dest_d    = iss2_dest_q;
        if (!iss_stall) begin
            iss1_valid_d   = sel1_found;
            iss1_payload_d = sel1_found ? entry_q[sel1_idx].payload : '0;
            iss1_dest_d    = sel_inst1_dest;
            iss2_valid_d   = sel2_found;
            iss2_payload_d = sel2_found ? entry_q[sel2_idx].payload : '0;
            iss2_dest_d    = sel_inst2_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q        <= '0;
            iss1_valid_q   <= 1'b0;
            iss1_payload_q <= '0;
            iss1_dest_q    <= '0;
            iss2_valid_q   <= 1'b0;
            iss2_payload_q <= '0;
            iss2_dest_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            count_q        <= count_d;
            iss1_valid_q   <= iss1_valid_d;
            iss1_payload_q <= iss1_payload_d;
            iss1_dest_q    <= iss1_dest_d;
            iss2_valid_q   <= iss2_valid_d;
            iss2_payload_q <= iss2_payload_d;
            iss2_dest_q    <= iss2_dest_d;
        end
    end

    assign iss_inst1_valid   = iss1_valid_q;
    assign iss_inst1_payload = iss1_payload_q;
    assign iss_inst1_dest    = iss1_dest_q;
    assign iss_inst2_valid   = iss2_valid_q;
    assign iss_inst2_payload = iss2_payload_q;
    assign iss_inst2_dest    = iss2_dest_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed testbench for issue_queue. Each table row holds one cycle of
// inputs and the outputs expected during that same cycle, sampled 2 time
// units after the falling edge. Short hand-written sequences cover the
// reset state and a reset landing in the middle of traffic.
module tb_issue_queue;
    typedef struct packed {
        logic        v;
        logic [63:0] p;
        logic [4:0]  s1;
        logic        r1;
        logic [4:0]  s2;
        logic        r2;
        logic [4:0]  d;
        logic        we;
    } inst_t;

    typedef struct packed {
        logic        v;
        logic [63:0] p;
        logic [4:0]  d;
    } iss_t;

    typedef struct {
        inst_t      i1;
        inst_t      i2;
        logic [4:0] wb1;
        logic [4:0] wb2;
        logic       stall;
        logic       flush;
        logic       dr;
        logic [4:0] sel1;
        logic [4:0] sel2;
        iss_t       o1;
        iss_t       o2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, iss_stall;
    logic        disp_inst1_valid, disp_inst1_src1_ready, disp_inst1_src2_ready, disp_inst1_rf_we;
    logic        disp_inst2_valid, disp_inst2_src1_ready, disp_inst2_src2_ready, disp_inst2_rf_we;
    logic [63:0] disp_inst1_payload, disp_inst2_payload;
    logic [4:0]  disp_inst1_src1, disp_inst1_src2, disp_inst1_dest;
    logic [4:0]  disp_inst2_src1, disp_inst2_src2, disp_inst2_dest;
    logic [4:0]  wb_inst1_dest, wb_inst2_dest;
    logic        disp_ready, iss_inst1_valid, iss_inst2_valid;
    logic [63:0] iss_inst1_payload, iss_inst2_payload;
    logic [4:0]  iss_inst1_dest, iss_inst2_dest, sel_inst1_dest, sel_inst2_dest;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_inst1_valid(disp_inst1_valid), .disp_inst1_payload(disp_inst1_payload),
        .disp_inst1_src1(disp_inst1_src1), .disp_inst1_src2(disp_inst1_src2),
        .disp_inst1_src1_ready(disp_inst1_src1_ready), .disp_inst1_src2_ready(disp_inst1_src2_ready),
        .disp_inst1_dest(disp_inst1_dest), .disp_inst1_rf_we(disp_inst1_rf_we),
        .disp_inst2_valid(disp_inst2_valid), .disp_inst2_payload(disp_inst2_payload),
        .disp_inst2_src1(disp_inst2_src1), .disp_inst2_src2(disp_inst2_src2),
        .disp_inst2_src1_ready(disp_inst2_src1_ready), .disp_inst2_src2_ready(disp_inst2_src2_ready),
        .disp_inst2_dest(disp_inst2_dest), .disp_inst2_rf_we(disp_inst2_rf_we),
        .disp_ready(disp_ready),
        .wb_inst1_dest(wb_inst1_dest), .wb_inst2_dest(wb_inst2_dest),
        .iss_stall(iss_stall),
        .iss_inst1_valid(iss_inst1_valid), .iss_inst1_payload(iss_inst1_payload),
        .iss_inst1_dest(iss_inst1_dest),
        .iss_inst2_valid(iss_inst2_valid), .iss_inst2_payload(iss_inst2_payload),
        .iss_inst2_dest(iss_inst2_dest),
        .sel_inst1_dest(sel_inst1_dest), .sel_inst2_dest(sel_inst2_dest)
    );

    function automatic inst_t ins(input logic [63:0] p, input logic [4:0] s1, input logic r1,
                                  input logic [4:0] s2, input logic r2, input logic [4:0] d,
                                  input logic we);
        inst_t t;
        t.v = 1'b1; t.p = p; t.s1 = s1; t.r1 = r1; t.s2 = s2; t.r2 = r2; t.d = d; t.we = we;
        return t;
    endfunction

    function automatic iss_t io(input logic [63:0] p, input logic [4:0] d);
        iss_t t;
        t.v = 1'b1; t.p = p; t.d = d;
        return t;
    endfunction

    function automatic vec_t mv(input inst_t i1, input inst_t i2, input logic [4:0] wb1,
                                input logic [4:0] wb2, input logic stall, input logic fl,
                                input logic dr, input logic [4:0] s1, input logic [4:0] s2,
                                input iss_t o1, input iss_t o2);
        vec_t v;
        v.i1 = i1; v.i2 = i2; v.wb1 = wb1; v.wb2 = wb2; v.stall = stall; v.flush = fl;
        v.dr = dr; v.sel1 = s1; v.sel2 = s2; v.o1 = o1; v.o2 = o2;
        return v;
    endfunction

    // Instruction waiting on r7, used to fill the queue.
    function automatic inst_t e7(input int k);
        return ins(64'h100 + 64'(k), 5'd7, 1'b0, 5'd0, 1'b1, 5'(16 + k), 1'b1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        disp_inst1_valid      = v.i1.v;  disp_inst1_payload    = v.i1.p;
        disp_inst1_src1       = v.i1.s1; disp_inst1_src1_ready = v.i1.r1;
        disp_inst1_src2       = v.i1.s2; disp_inst1_src2_ready = v.i1.r2;
        disp_inst1_dest       = v.i1.d;  disp_inst1_rf_we      = v.i1.we;
        disp_inst2_valid      = v.i2.v;  disp_inst2_payload    = v.i2.p;
        disp_inst2_src1       = v.i2.s1; disp_inst2_src1_ready = v.i2.r1;
        disp_inst2_src2       = v.i2.s2; disp_inst2_src2_ready = v.i2.r2;
        disp_inst2_dest       = v.i2.d;  disp_inst2_rf_we      = v.i2.we;
        wb_inst1_dest         = v.wb1;   wb_inst2_dest         = v.wb2;
        iss_stall             = v.stall; flush                 = v.flush;
    endtask

    initial begin
        inst_t ni, jk;
        iss_t  nx;
        vec_t  idle;
        ni = '0;
        nx = '0;
        jk = ins(64'hBAD, 5'd0, 1'b1, 5'd0, 1'b1, 5'd30, 1'b1);
        idle = mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx);

        // Two independent ready instructions.
        vecs.push_back(mv(ins(64'h11, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1),
                          ins(64'h22, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1),
                          5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd4, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h11, 5'd3), io(64'h22, 5'd4)));
        vecs.push_back(idle);
        // Back-to-back dependent; B src2=0 with ready bit low is still ready.
        vecs.push_back(mv(ins(64'h33, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1),
                          ins(64'h44, 5'd5, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1),
                          5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd0, io(64'h33, 5'd5), nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h44, 5'd6), nx));
        vecs.push_back(idle);
        // Dispatch bypass from wb2; D (rf_we=0) waits on r12, wb tag 0 wakes nothing.
        vecs.push_back(mv(ins(64'h55, 5'd1, 1'b1, 5'd9, 1'b0, 5'd10, 1'b1),
                          ins(64'h66, 5'd12, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0),
                          5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h55, 5'd10), nx));
        vecs.push_back(mv(ni, ni, 5'd12, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(idle);
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h66, 5'd0), nx));
        vecs.push_back(idle);
        // Fill all eight entries on r7, junk at full is dropped, then drain.
        vecs.push_back(mv(e7(0), e7(1), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(e7(2), e7(3), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(e7(4), e7(5), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(e7(6), e7(7), 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(jk, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd16, 5'd17, nx, nx));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd18, 5'd19, io(64'h100, 5'd16), io(64'h101, 5'd17)));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20, 5'd21, io(64'h102, 5'd18), io(64'h103, 5'd19)));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd22, 5'd23, io(64'h104, 5'd20), io(64'h105, 5'd21)));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h106, 5'd22), io(64'h107, 5'd23)));
        vecs.push_back(idle);
        // Issue + dispatch same cycle, then a 3-cycle stall reaching count 7.
        vecs.push_back(mv(ins(64'h200, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1),
                          ins(64'h201, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1),
                          5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        vecs.push_back(mv(ins(64'h210, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1),
                          ins(64'h211, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1),
                          5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, nx, nx));
        vecs.push_back(mv(ins(64'h212, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1),
                          ins(64'h220, 5'd20, 1'b0, 5'd0, 1'b1, 5'd12, 1'b1),
                          5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h200, 5'd1), io(64'h201, 5'd2)));
        vecs.push_back(mv(ins(64'h221, 5'd20, 1'b0, 5'd0, 1'b1, 5'd13, 1'b1),
                          ins(64'h222, 5'd20, 1'b0, 5'd0, 1'b1, 5'd14, 1'b1),
                          5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h200, 5'd1), io(64'h201, 5'd2)));
        vecs.push_back(mv(ins(64'h223, 5'd20, 1'b0, 5'd0, 1'b1, 5'd15, 1'b1), ni,
                          5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h200, 5'd1), io(64'h201, 5'd2)));
        vecs.push_back(mv(jk, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, io(64'h200, 5'd1), io(64'h201, 5'd2)));
        vecs.push_back(mv(ni, ni, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 5'd0, io(64'h210, 5'd8), io(64'h211, 5'd9)));
        // Flush mid-stall with five entries; dispatch and wakeup in that cycle are dropped.
        vecs.push_back(mv(ins(64'h300, 5'd20, 1'b0, 5'd0, 1'b1, 5'd17, 1'b1), ni,
                          5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, io(64'h212, 5'd10), nx));
        vecs.push_back(mv(ins(64'h400, 5'd0, 1'b1, 5'd0, 1'b1, 5'd25, 1'b1),
                          ins(64'h401, 5'd0, 1'b1, 5'd0, 1'b1, 5'd26, 1'b1),
                          5'd20, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, io(64'h212, 5'd10), nx));
        vecs.push_back(idle);
        vecs.push_back(idle);

        // Reset state.
        reset = 1'b1;
        drive(idle);
        repeat (3) @(negedge clk);
        #2;
        chk("reset disp_ready", 64'(disp_ready), 64'd1);
        chk("reset iss1_valid", 64'(iss_inst1_valid), 64'd0);
        chk("reset iss2_valid", 64'(iss_inst2_valid), 64'd0);
        chk("reset iss1_payload", iss_inst1_payload, 64'd0);
        chk("reset iss2_payload", iss_inst2_payload, 64'd0);
        chk("reset iss1_dest", 64'(iss_inst1_dest), 64'd0);
        chk("reset iss2_dest", 64'(iss_inst2_dest), 64'd0);
        chk("reset sel1", 64'(sel_inst1_dest), 64'd0);
        chk("reset sel2", 64'(sel_inst2_dest), 64'd0);
        $display("reset: disp_ready=%0b iss_valid=%0b/%0b", disp_ready, iss_inst1_valid, iss_inst2_valid);
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k]);
            #2;
            chk($sformatf("v%0d disp_ready", k), 64'(disp_ready), 64'(vecs[k].dr));
            chk($sformatf("v%0d sel1", k), 64'(sel_inst1_dest), 64'(vecs[k].sel1));
            chk($sformatf("v%0d sel2", k), 64'(sel_inst2_dest), 64'(vecs[k].sel2));
            chk($sformatf("v%0d iss1_valid", k), 64'(iss_inst1_valid), 64'(vecs[k].o1.v));
            chk($sformatf("v%0d iss2_valid", k), 64'(iss_inst2_valid), 64'(vecs[k].o2.v));
            if (vecs[k].o1.v) begin
                chk($sformatf("v%0d iss1_payload", k), iss_inst1_payload, vecs[k].o1.p);
                chk($sformatf("v%0d iss1_dest", k), 64'(iss_inst1_dest), 64'(vecs[k].o1.d));
            end
            if (vecs[k].o2.v) begin
                chk($sformatf("v%0d iss2_payload", k), iss_inst2_payload, vecs[k].o2.p);
                chk($sformatf("v%0d iss2_dest", k), 64'(iss_inst2_dest), 64'(vecs[k].o2.d));
            end
            $display("v%0d: dr=%0b sel=%0d/%0d iss1=%0b:%0h:%0d iss2=%0b:%0h:%0d", k, disp_ready,
                     sel_inst1_dest, sel_inst2_dest, iss_inst1_valid, iss_inst1_payload,
                     iss_inst1_dest, iss_inst2_valid, iss_inst2_payload, iss_inst2_dest);
        end

        // Reset arriving while two instructions are being selected.
        @(negedge clk);
        drive(mv(ins(64'h500, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1),
                 ins(64'h501, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1),
                 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, nx, nx));
        #2;
        chk("midreset pre sel1", 64'(sel_inst1_dest), 64'd0);
        $display("midreset dispatch: sel=%0d/%0d", sel_inst1_dest, sel_inst2_dest);
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        #2;
        chk("midreset sel1", 64'(sel_inst1_dest), 64'd3);
        chk("midreset sel2", 64'(sel_inst2_dest), 64'd4);
        $display("midreset select: sel=%0d/%0d", sel_inst1_dest, sel_inst2_dest);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("postreset iss1_valid", 64'(iss_inst1_valid), 64'd0);
        chk("postreset iss2_valid", 64'(iss_inst2_valid), 64'd0);
        chk("postreset sel1", 64'(sel_inst1_dest), 64'd0);
        chk("postreset disp_ready", 64'(disp_ready), 64'd1);
        $display("postreset: iss_valid=%0b/%0b sel=%0d dr=%0b", iss_inst1_valid, iss_inst2_valid,
                 sel_inst1_dest, disp_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
